// File: rtl/audio_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared types and constants for the WM8731 audio path
//                (deserializer FSM states, channel encoding, default width).
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Sample width shared with the transmit-side serializer.
    localparam int c_data_w_default = 24;

    // I2S LRCK encoding: low = left, high = right.
    localparam logic c_chan_left  = 1'b0;
    localparam logic c_chan_right = 1'b1;

    // Receive FSM states.
    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/audio_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : audio_deserializer_if
//  Description : Avalon-ST style sample-pair stream.
//                source_data  : {left, right}, left in the MSBs
//                source_valid : pair available
//                source_ready : sink accepts the pair
//                master = producer (deserializer), slave = consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface audio_deserializer_if import audio_pkg::*; #(
    parameter int DATA_W = c_data_w_default
);
    logic [2*DATA_W-1:0] source_data;
    logic                source_valid;
    logic                source_ready;

    modport master (
        output source_data,
        output source_valid,
        input  source_ready
    );

    modport slave (
        input  source_data,
        input  source_valid,
        output source_ready
    );
endinterface
`default_nettype wire

// File: rtl/audio_deserializer_sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Multi-stage synchronizer for an asynchronous input plus a
//                one-clk rising-edge strobe on the synchronized value.
//                clk, reset : system clock, synchronous active-high reset
//                i_din      : asynchronous input
//                o_sync     : synchronized level
//                o_rise     : one-clk pulse on a synchronized 0->1 transition
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_din,
    output logic      o_sync,
    output logic      o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/audio_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_deserializer
//  Description : Captures the WM8731 ADC I2S stream (codec is bus master) and
//                delivers {left, right} sample pairs on a one-entry
//                Avalon-ST source buffer.
//                clk, reset     : system clock (>= 4x bclk), sync reset
//                bclk, adclrck,
//                adcdat         : asynchronous codec pins
//                src            : sample-pair stream (master modport)
//                overrun        : sticky, a pair was dropped
//                overrun_clr    : clears overrun (set wins)
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_deserializer import audio_pkg::*; #(
    parameter int DATA_W      = c_data_w_default,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               bclk,
    input  wire logic               adclrck,
    input  wire logic               adcdat,
    audio_deserializer_if.master    src,
    output logic                    overrun,
    input  wire logic               overrun_clr
);

    localparam int                c_cnt_w   = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] c_msb_one = {1'b1, {(DATA_W-1){1'b0}}};

    logic w_bit_en, w_lrck_s, w_dat_s;
    logic w_lrck_rise_unused, w_dat_rise_unused;

    // Identical synchronizer depth on all three pins keeps data and lrck
    // aligned to the synchronized bclk edge that samples them.
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(clk), .reset(reset), .i_din(bclk),
        .o_sync(), .o_rise(w_bit_en)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk(clk), .reset(reset), .i_din(adclrck),
        .o_sync(w_lrck_s), .o_rise(w_lrck_rise_unused)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
        .clk(clk), .reset(reset), .i_din(adcdat),
        .o_sync(w_dat_s), .o_rise(w_dat_rise_unused)
    );

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_left_hold;
    logic               r_lrck_q;

    logic [2*DATA_W-1:0] r_source_data;
    logic                r_source_valid;
    logic                r_overrun;

    logic              w_boundary;
    logic              w_last_bit;
    logic [DATA_W-1:0] w_shift_next;
    logic              w_store;
    logic [DATA_W-1:0] w_word;
    logic              w_pair_done;
    logic              w_drop;

    assign w_boundary = (w_lrck_s != r_lrck_q);
    assign w_last_bit = (r_cnt == c_cnt_w'(DATA_W - 1));

    // Bits are placed at their final position (MSB down), so a word cut short
    // by a boundary is already left-justified with zero LSBs.
    assign w_shift_next = w_dat_s ? (r_shift | (c_msb_one >> r_cnt)) : r_shift;

    always_comb begin
        w_store = 1'b0;
        w_word  = w_shift_next;
        if (w_bit_en && (r_state == ST_SHIFT)) begin
            if (w_boundary) begin
                w_store = 1'b1;
                w_word  = r_shift;
            end else if (w_last_bit) begin
                w_store = 1'b1;
            end
        end
    end

    // While shifting, r_lrck_q still names the channel being received.
    assign w_pair_done = w_store && (r_lrck_q == c_chan_right);
    assign w_drop      = w_pair_done && r_source_valid && !src.source_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SYNC;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_lrck_q    <= 1'b0;
        end else if (w_bit_en) begin
            r_lrck_q <= w_lrck_s;
            case (r_state)
                ST_SYNC: begin
                    // Only a falling lrck starts capture, so pairs begin with left.
                    if (w_boundary && (w_lrck_s == c_chan_left))
                        r_state <= ST_SKIP;
                end
                ST_SKIP: begin
                    r_shift <= w_dat_s ? c_msb_one : '0;
                    r_cnt   <= c_cnt_w'(1);
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_boundary) begin
                        r_state <= ST_SKIP;
                    end else begin
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt + c_cnt_w'(1);
                        if (w_last_bit)
                            r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_boundary)
                        r_state <= ST_SKIP;
                end
                default: r_state <= ST_SYNC;
            endcase
            if (w_store && (r_lrck_q == c_chan_left))
                r_left_hold <= w_word;
        end
    end

    // One-entry output buffer; an accept in the same cycle frees the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_source_data  <= '0;
            r_source_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (w_pair_done && (!r_source_valid || src.source_ready)) begin
                r_source_data  <= {r_left_hold, w_word};
                r_source_valid <= 1'b1;
            end else if (r_source_valid && src.source_ready) begin
                r_source_valid <= 1'b0;
            end

            if (w_drop)
                r_overrun <= 1'b1;
            else if (overrun_clr)
                r_overrun <= 1'b0;
        end
    end

    assign src.source_data  = r_source_data;
    assign src.source_valid = r_source_valid;
    assign overrun          = r_overrun;

endmodule
`default_nettype wire
